bids22_host_seq: RTL
====================

// Module: bids22_host_seq
// PURPOSE
//  Host-side command sequencer for the bids22 auction controller; drives its C_op/C_data/C_start port.
//  On a go pulse it runs one full auction round:
//    program balances, mask, timer and bid cost -> Lock(key) -> hold C_start for a round
//    -> wait for roundOver and capture the result -> Unlock(key), with a bounded retry on a bad key.
//  Sits between the testbench/SoC configuration logic and bids22.
// PARAMETERS
//  ROUND_CYCLES    16  cycles C_start is held high per round (>=1)
//  UNLOCK_RETRIES  2   extra Unlock attempts after a bad-key error
//  TIMEOUT_CYCLES  64  roundOver watchdog limit (used only with BIDS22_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  go           in   1   start pulse; ignored while busy
//  cfg_x_bal    in   32  X balance (LoadX); captured on accepted go
//  cfg_y_bal    in   32  Y balance (LoadY); captured on accepted go
//  cfg_z_bal    in   32  Z balance (LoadZ); captured on accepted go
//  cfg_mask     in   3   XYZ enable mask; captured on accepted go
//  cfg_timer    in   32  lockout timer value; captured on accepted go
//  cfg_bid_cost in   32  per-bid charge; captured on accepted go
//  cfg_key      in   32  lock/unlock key; captured on accepted go
//  C_op         out  4   opcode to bids22 (registered)
//  C_data       out  32  command data to bids22 (registered)
//  C_start      out  1   round-active to bids22 (registered)
//  ready        in   1   bids22 ready
//  err          in   2   bids22 error code
//  roundOver    in   1   bids22 round complete
//  maxBid       in   32  winning amount
//  X_win        in   1   bidder X won
//  Y_win        in   1   bidder Y won
//  Z_win        in   1   bidder Z won
//  busy         out  1   sequence in progress
//  done         out  1   one-cycle pulse at end of sequence
//  res_maxbid   out  32  captured maxBid
//  res_winner   out  2   0 none, 1 X, 2 Y, 3 Z
//  res_status   out  2   0 OK, 1 cmd error, 2 unlock failed, 3 timeout
// BEHAVIOUR
//  Reset: C_op=NoOp, C_data=0, C_start=0, busy=0, done=0, res_*=0, state=IDLE.
//    Reset mid-sequence aborts immediately with no further commands.
//  States: IDLE, CMD, ROUND, ENDWAIT, UNLOCK, UNLOCK_CHK, BACKOFF, FIN.
//  IDLE: go=1 captures all cfg_* and sets busy=1 the next cycle -> CMD, index 0.
//  CMD order: LoadX, LoadY, LoadZ, SetXYZmask({29'b0,mask}), SetTimer, BidCharge, Lock(key).
//    A command is accepted on an edge where C_op!=NoOp and ready=1; it holds unchanged while ready=0.
//    After acceptance C_op=NoOp for one cycle and err is sampled.
//    err!=0 -> res_status=1 -> FIN (Unlock is not sent).
//    After Lock accepted with err==0 -> ROUND.
//  ROUND: C_start=1 for exactly ROUND_CYCLES cycles, C_op=NoOp, then C_start=0 -> ENDWAIT.
//  ENDWAIT: on the first cycle with roundOver=1 capture maxBid and the winner -> UNLOCK.
//    Winner: one-hot win -> 1/2/3; zero or multiple wins -> 0. Simultaneous roundOver and timeout -> roundOver wins.
//  UNLOCK: C_op=Unlock, C_data=key, held until ready=1 -> UNLOCK_CHK. Sample err the next cycle.
//    err==0 -> FIN.
//    Else if retries left -> BACKOFF for cfg_timer+2 cycles (32-bit down-counter, saturates at 0; cfg_timer=FFFF_FFFF must not wrap) -> UNLOCK.
//    Else res_status=2 -> FIN.
//  FIN: done=1 for one cycle, busy=0 -> IDLE. res_* hold until the next accepted go clears them.
//  go while busy is ignored. go in the FIN cycle is ignored.
// CONFIGURATION
//  BIDS22_SEQ_TIMEOUT_EN defined: ENDWAIT counts cycles; reaching TIMEOUT_CYCLES without roundOver
//    -> res_status=3, res_winner=0 -> UNLOCK.
//  BIDS22_SEQ_TIMEOUT_EN undefined: ENDWAIT waits indefinitely; no counter is synthesised.
// STRUCTURE
//  bids22_pkg: opcode enum (NoOp=0 Unlock=1 Lock=2 LoadX=3 LoadY=4 LoadZ=5 SetXYZmask=6 SetTimer=7 BidCharge=8),
//    seq state enum, res_status and res_winner encodings.
//  One sub-module, bids22_seq_cnt: loadable 32-bit down-counter with zero flag,
//    shared by ROUND, BACKOFF and the timeout (one active at a time).
// TESTING
//  T1 Nominal: cfg X/Y/Z=100/200/300, mask=7, key=0F0F0F0F, ready=1, err=0
//     -> ops 3,4,5,6,7,8,2 on consecutive accepted cycles; C_start high exactly 16 cycles.
//  T2 Result capture: roundOver=1, maxBid=42, Y_win=1 -> Unlock(0F0F0F0F), done pulse,
//     res_maxbid=42, res_winner=2, res_status=0.
//  T3 Backpressure: ready=0 for 5 cycles during LoadY -> C_op=4 and C_data stable throughout;
//     exactly one LoadY accepted.
//  T4 Command error: err=2'b11 after SetXYZmask -> no Lock sent, res_status=1, done within 2 cycles.
//  T5 Bad key: err=2'b01 after each Unlock, cfg_timer=3 -> 3 Unlock attempts,
//     5-cycle gaps between them, res_status=2.
//  T6 Reset/timeout: reset_n low during ROUND -> C_start=0 and busy=0 asynchronously.
//     With BIDS22_SEQ_TIMEOUT_EN and no roundOver -> res_status=3 after 64 cycles, then Unlock.

Source files
------------

// File: rtl/bids22_pkg.sv
// Shared types for the bids22 host sequencer: opcodes, sequencer states,
// result encodings and the command-table / winner decode helpers.
package bids22_pkg;

  typedef enum logic [3:0] {
    OP_NOOP       = 4'd0,
    OP_UNLOCK     = 4'd1,
    OP_LOCK       = 4'd2,
    OP_LOADX      = 4'd3,
    OP_LOADY      = 4'd4,
    OP_LOADZ      = 4'd5,
    OP_SETXYZMASK = 4'd6,
    OP_SETTIMER   = 4'd7,
    OP_BIDCHARGE  = 4'd8
  } bids22_op_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CMD        = 3'd1,
    S_ROUND      = 3'd2,
    S_ENDWAIT    = 3'd3,
    S_UNLOCK     = 3'd4,
    S_UNLOCK_CHK = 3'd5,
    S_BACKOFF    = 3'd6,
    S_FIN        = 3'd7
  } seq_state_e;

  localparam logic [1:0] RES_OK          = 2'd0;
  localparam logic [1:0] RES_CMD_ERR     = 2'd1;
  localparam logic [1:0] RES_UNLOCK_FAIL = 2'd2;
  localparam logic [1:0] RES_TIMEOUT     = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_X    = 2'd1;
  localparam logic [1:0] WIN_Y    = 2'd2;
  localparam logic [1:0] WIN_Z    = 2'd3;

  localparam logic [2:0] CMD_LAST = 3'd6;

  // Command table: index 0..6 walks the configuration sequence ending in Lock.
  function automatic bids22_op_e cmd_op(input logic [2:0] idx);
    case (idx)
      3'd0:    return OP_LOADX;
      3'd1:    return OP_LOADY;
      3'd2:    return OP_LOADZ;
      3'd3:    return OP_SETXYZMASK;
      3'd4:    return OP_SETTIMER;
      3'd5:    return OP_BIDCHARGE;
      3'd6:    return OP_LOCK;
      default: return OP_NOOP;
    endcase
  endfunction

  // Only a strictly one-hot win vector names a winner.
  function automatic logic [1:0] winner_code(input logic x, input logic y, input logic z);
    case ({x, y, z})
      3'b100:  return WIN_X;
      3'b010:  return WIN_Y;
      3'b001:  return WIN_Z;
      default: return WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bids22_host_seq_if.sv
// Command/result port between the host sequencer (master) and bids22 (slave).
interface bids22_host_seq_if;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready;
  logic [1:0]  err;
  logic        roundOver;
  logic [31:0] maxBid;
  logic        X_win;
  logic        Y_win;
  logic        Z_win;

  modport master (
    output C_op, C_data, C_start,
    input  ready, err, roundOver, maxBid, X_win, Y_win, Z_win
  );

  modport slave (
    input  C_op, C_data, C_start,
    output ready, err, roundOver, maxBid, X_win, Y_win, Z_win
  );
endinterface

// File: rtl/bids22_seq_cnt.sv
// Loadable 32-bit down-counter with zero flag, time-shared between the round
// length, the unlock back-off and the optional roundOver watchdog.
module bids22_seq_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [31:0] count_r;

  // Load has priority; decrement saturates at zero so a huge load never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 32'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 32'd0)) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 32'd0);

endmodule

// File: rtl/bids22_host_seq.sv
// Host command sequencer for bids22: configure, lock, run one round, capture the
// result, unlock with bounded retry. Define BIDS22_SEQ_TIMEOUT_EN for the roundOver watchdog.
module bids22_host_seq
  import bids22_pkg::*;
#(
  parameter int ROUND_CYCLES   = 16,
  parameter int UNLOCK_RETRIES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      go,
  input  logic [31:0]               cfg_x_bal,
  input  logic [31:0]               cfg_y_bal,
  input  logic [31:0]               cfg_z_bal,
  input  logic [2:0]                cfg_mask,
  input  logic [31:0]               cfg_timer,
  input  logic [31:0]               cfg_bid_cost,
  input  logic [31:0]               cfg_key,
  bids22_host_seq_if.master         bus,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               res_maxbid,
  output logic [1:0]                res_winner,
  output logic [1:0]                res_status
);

  localparam logic [31:0] ROUND_LOAD = 32'(ROUND_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(UNLOCK_RETRIES);
`ifdef BIDS22_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
`endif

  seq_state_e  state_r;
  logic [2:0]  idx_r;
  logic        chk_r;
  logic [7:0]  retry_r;
  bids22_op_e  c_op_r;
  logic [31:0] c_data_r;
  logic        c_start_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] res_maxbid_r;
  logic [1:0]  res_winner_r;
  logic [1:0]  res_status_r;
  logic [31:0] y_bal_r;
  logic [31:0] z_bal_r;
  logic [2:0]  mask_r;
  logic [31:0] timer_r;
  logic [31:0] cost_r;
  logic [31:0] key_r;

  logic [2:0]  nxt_idx_s;
  logic [31:0] nxt_data_s;
  logic        cnt_load_s;
  logic [31:0] cnt_val_s;
  logic        cnt_dec_s;
  logic        cnt_zero_s;

  bids22_seq_cnt u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Payload for the command following the current one (LoadX comes straight from cfg at go).
  always_comb begin
    nxt_idx_s  = idx_r + 3'd1;
    nxt_data_s = 32'd0;
    case (nxt_idx_s)
      3'd1:    nxt_data_s = y_bal_r;
      3'd2:    nxt_data_s = z_bal_r;
      3'd3:    nxt_data_s = {29'd0, mask_r};
      3'd4:    nxt_data_s = timer_r;
      3'd5:    nxt_data_s = cost_r;
      3'd6:    nxt_data_s = key_r;
      default: nxt_data_s = 32'd0;
    endcase
  end

  // Counter steering. The unlock check cycle is the first back-off cycle, so loading
  // cfg_timer gives cfg_timer+2 idle cycles between Unlock attempts without any +2 overflow.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_val_s  = 32'd0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      S_CMD: begin
        if (chk_r && (bus.err == 2'b00) && (idx_r == CMD_LAST)) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = ROUND_LOAD;
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      S_ROUND: begin
        if (cnt_zero_s) begin
`ifdef BIDS22_SEQ_TIMEOUT_EN
          cnt_load_s = 1'b1;
          cnt_val_s  = TIMEOUT_LOAD;
`else
          cnt_load_s = 1'b0;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      S_ENDWAIT: begin
`ifdef BIDS22_SEQ_TIMEOUT_EN
        cnt_dec_s = 1'b1;
`else
        cnt_dec_s = 1'b0;
`endif
      end
      S_UNLOCK_CHK: begin
        if (bus.err != 2'b00) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = timer_r;
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      S_BACKOFF: cnt_dec_s = 1'b1;
      default:   cnt_dec_s = 1'b0;
    endcase
  end

  // Sequencer FSM with all bus and result outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      idx_r        <= 3'd0;
      chk_r        <= 1'b0;
      retry_r      <= 8'd0;
      c_op_r       <= OP_NOOP;
      c_data_r     <= 32'd0;
      c_start_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      res_maxbid_r <= 32'd0;
      res_winner_r <= WIN_NONE;
      res_status_r <= RES_OK;
      y_bal_r      <= 32'd0;
      z_bal_r      <= 32'd0;
      mask_r       <= 3'd0;
      timer_r      <= 32'd0;
      cost_r       <= 32'd0;
      key_r        <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (go) begin
            y_bal_r      <= cfg_y_bal;
            z_bal_r      <= cfg_z_bal;
            mask_r       <= cfg_mask;
            timer_r      <= cfg_timer;
            cost_r       <= cfg_bid_cost;
            key_r        <= cfg_key;
            res_maxbid_r <= 32'd0;
            res_winner_r <= WIN_NONE;
            res_status_r <= RES_OK;
            retry_r      <= 8'd0;
            idx_r        <= 3'd0;
            chk_r        <= 1'b0;
            c_op_r       <= cmd_op(3'd0);
            c_data_r     <= cfg_x_bal;
            busy_r       <= 1'b1;
            state_r      <= S_CMD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CMD: begin
          if (!chk_r) begin
            if (bus.ready) begin
              c_op_r <= OP_NOOP;
              chk_r  <= 1'b1;
            end else begin
              chk_r <= 1'b0;
            end
          end else if (bus.err != 2'b00) begin
            res_status_r <= RES_CMD_ERR;
            chk_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            state_r      <= S_FIN;
          end else if (idx_r == CMD_LAST) begin
            chk_r     <= 1'b0;
            c_start_r <= 1'b1;
            state_r   <= S_ROUND;
          end else begin
            chk_r    <= 1'b0;
            idx_r    <= nxt_idx_s;
            c_op_r   <= cmd_op(nxt_idx_s);
            c_data_r <= nxt_data_s;
          end
        end
        S_ROUND: begin
          if (cnt_zero_s) begin
            c_start_r <= 1'b0;
            state_r   <= S_ENDWAIT;
          end else begin
            state_r <= S_ROUND;
          end
        end
        S_ENDWAIT: begin
          if (bus.roundOver) begin
            res_maxbid_r <= bus.maxBid;
            res_winner_r <= winner_code(bus.X_win, bus.Y_win, bus.Z_win);
            c_op_r       <= OP_UNLOCK;
            c_data_r     <= key_r;
            state_r      <= S_UNLOCK;
`ifdef BIDS22_SEQ_TIMEOUT_EN
          end else if (cnt_zero_s) begin
            res_status_r <= RES_TIMEOUT;
            res_winner_r <= WIN_NONE;
            c_op_r       <= OP_UNLOCK;
            c_data_r     <= key_r;
            state_r      <= S_UNLOCK;
`endif
          end else begin
            state_r <= S_ENDWAIT;
          end
        end
        S_UNLOCK: begin
          if (bus.ready) begin
            c_op_r  <= OP_NOOP;
            state_r <= S_UNLOCK_CHK;
          end else begin
            state_r <= S_UNLOCK;
          end
        end
        S_UNLOCK_CHK: begin
          if (bus.err == 2'b00) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else if (retry_r < RETRY_MAX) begin
            retry_r <= retry_r + 8'd1;
            state_r <= S_BACKOFF;
          end else begin
            res_status_r <= RES_UNLOCK_FAIL;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            state_r      <= S_FIN;
          end
        end
        S_BACKOFF: begin
          if (cnt_zero_s) begin
            c_op_r   <= OP_UNLOCK;
            c_data_r <= key_r;
            state_r  <= S_UNLOCK;
          end else begin
            state_r <= S_BACKOFF;
          end
        end
        S_FIN: begin
          state_r <= S_IDLE;
        end
        default: begin
          c_op_r    <= OP_NOOP;
          c_start_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.C_op    = c_op_r;
  assign bus.C_data  = c_data_r;
  assign bus.C_start = c_start_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign res_maxbid  = res_maxbid_r;
  assign res_winner  = res_winner_r;
  assign res_status  = res_status_r;

endmodule
